bcd_to_bin_seq: RTL
===================

// Module: bcd_to_bin_seq
// PURPOSE
// - Iterative packed-BCD to unsigned-binary converter; inverse of the binary-to-BCD display path.
// - Accepts DIGITS BCD digits (e.g. from keypad/switch entry) and returns the binary value.
// - Uses reverse double-dabble, one shift/correct step per clock, with valid/ready on both sides.
// PARAMETERS
// - DIGITS  3   number of BCD digits at the input (>=1)
// - BIN_W   10  output width; must be >= ceil(log2(10**DIGITS)); also the iteration count
// PORTS
// - clk        in   1          single clock, rising edge
// - rst        in   1          synchronous, active-high reset
// - in_valid   in   1          bcd_in holds a value to convert
// - in_ready   out  1          converter idle; may accept
// - bcd_in     in   4*DIGITS   packed BCD, digit 0 in [3:0]
// - out_valid  out  1          bin_out/err valid; held until consumed
// - out_ready  in   1          consumer accepts result
// - bin_out    out  BIN_W      converted value
// - err        out  1          invalid input digit (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, count=0, work regs=0.
// - FSM IDLE -> SHIFT -> DONE -> IDLE.
// - IDLE: in_ready=1. Edge with in_valid=1 is the accept edge E0: load bcd reg=bcd_in,
//   bin reg=0, count=0, next state SHIFT. in_ready=0 outside IDLE.
// - SHIFT: each edge: {bcd,bin} >>= 1 (bcd LSB enters bin MSB); then every 4-bit bcd
//   digit >= 8 is decreased by 3; count++. After BIN_W steps -> DONE.
// - Latency: out_valid rises in the cycle after edge E_BIN_W (BIN_W clocks after E0).
// - DONE: out_valid=1, bin_out=bin reg, both stable until out_valid&&out_ready edge -> IDLE.
// - Throughput: one conversion per BIN_W+2 clocks minimum; no back-to-back accept while
//   DONE (in_ready returns high the cycle after the handshake).
// - in_valid while busy is ignored; bcd_in is sampled at E0 only.
// - out_ready before out_valid has no effect; out_ready held high gives a 1-cycle out_valid.
// - rst mid-SHIFT or mid-DONE: conversion discarded, reset values next cycle, result lost.
// - Arithmetic: unsigned only; the result is exact for all valid inputs 0..10**DIGITS-1.
// CONFIGURATION
// - Macro BCD_TO_BIN_ERR_CHECK_EN.
// - Defined: at E0 every digit is checked (>9 is invalid). If any digit is invalid, the
//   err flag is latched, SHIFT still runs, and DONE presents bin_out=0, err=1 with
//   identical latency. err clears on the output handshake or on rst.
// - Undefined: no checking; err is tied 0; invalid digits give unspecified bin_out.
// STRUCTURE
// - Package bcd_pkg: DIGIT_W=4 localparam, state enum {IDLE,SHIFT,DONE}, function
//   digit_valid(logic [3:0]) returning 1 for digits 0..9.
// - Sub-module bcd_rdd_step: combinational, parameter DIGITS; in {bcd,bin-bit}, out
//   shifted+corrected bcd and the shifted-out bit. The top handles FSM, counter, registers.
// - Counter width $clog2(BIN_W+1).
// TESTING
// - 0x000 -> 0 after 10 clks, err=0; next accept possible after handshake.
// - 0x999 -> 999 (0x3E7); out_valid exactly 10 clks after E0.
// - 0x512 -> 512 (0x200); 0x010 -> 10 (0x00A).
// - out_ready low 5 clks in DONE: out_valid/bin_out held; in_ready=0; second in_valid ignored.
// - With BCD_TO_BIN_ERR_CHECK_EN: 0x1A3 -> err=1, bin_out=0, same latency; next 0x123 -> 123, err=0.
// - rst asserted at step 4 of 0x999: next cycle in_ready=1, out_valid=0; new 0x042 -> 42.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and helpers for the BCD-to-binary converter
package bcd_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic digit_valid(input logic [3:0] d);
      return (d <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd_rdd_step.sv
// rtl/bcd_rdd_step.sv - one reverse double-dabble step: shift right, then -3 on digits >= 8
module bcd_rdd_step
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3
) (
   input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
   output logic [DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                      bit_out
);

   logic [DIGIT_W*DIGITS-1:0] shifted;

   assign shifted = bcd_in >> 1;
   assign bit_out = bcd_in[0];

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [DIGIT_W-1:0] d;
      assign d = shifted[i*DIGIT_W +: DIGIT_W];
      assign bcd_out[i*DIGIT_W +: DIGIT_W] = (d >= 4'd8) ? (d - 4'd3) : d;
   end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - iterative packed-BCD to binary converter, one step per clock
// Optional input digit checking enabled by BCD_TO_BIN_ERR_CHECK_EN.
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BIN_W-1:0]          bin_out,
   output logic                      err
);

   localparam int CNT_W = $clog2(BIN_W + 1);

   state_t                    state;
   logic [CNT_W-1:0]          count;
   logic [DIGIT_W*DIGITS-1:0] bcd_r;
   logic [DIGIT_W*DIGITS-1:0] bcd_next;
   logic [BIN_W-1:0]          bin_r;
   logic [BIN_W-1:0]          bin_next;
   logic                      shift_bit;

   bcd_rdd_step #(.DIGITS(DIGITS)) u_step (
      .bcd_in  (bcd_r),
      .bcd_out (bcd_next),
      .bit_out (shift_bit)
   );

   assign bin_next = {shift_bit, bin_r[BIN_W-1:1]};

`ifdef BCD_TO_BIN_ERR_CHECK_EN
   logic in_bad;
   logic err_flag;

   always_comb begin
      in_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!digit_valid(bcd_in[i*DIGIT_W +: DIGIT_W])) in_bad = 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         bin_out   <= '0;
         count     <= '0;
         bcd_r     <= '0;
         bin_r     <= '0;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
         err_flag  <= 1'b0;
         err       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  bcd_r    <= bcd_in;
                  bin_r    <= '0;
                  count    <= '0;
                  in_ready <= 1'b0;
                  state    <= SHIFT;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
                  err_flag <= in_bad;
`endif
               end
            end
            SHIFT: begin
               bcd_r <= bcd_next;
               bin_r <= bin_next;
               count <= count + CNT_W'(1);
               // Last step: publish the result directly from the step outputs
               if (count == CNT_W'(BIN_W - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
                  bin_out   <= err_flag ? '0 : bin_next;
                  err       <= err_flag;
`else
                  bin_out   <= bin_next;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
                  err       <= 1'b0;
                  err_flag  <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
